// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Definitions shared by the drop scheduler and its interval counter:
//   - state_t      : FSM state encoding (IDLE=0, FALL=1, LOCK=2, PAUSE=3)
//   - DEF_*_TOP    : default interval tops, in clk cycles minus one
//   - gravity_top  : level-dependent gravity top, saturated at a floor
// -----------------------------------------------------------------------------
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FALL  = 2'd1,
        ST_LOCK  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [24:0] DEF_BASE_TOP = 25'd12_000_000;
    localparam logic [24:0] DEF_STEP     = 25'd1_000_000;
    localparam logic [24:0] DEF_MIN_TOP  = 25'd1_000_000;
    localparam logic [24:0] DEF_SOFT_TOP = 25'd600_000;
    localparam logic [24:0] DEF_LOCK_TOP = 25'd6_000_000;

    // base - level*step, worked at 29 bits so the product cannot wrap.
    // A product larger than base means the difference went negative.
    function automatic logic [24:0] gravity_top(
        input logic [24:0] base,
        input logic [24:0] step,
        input logic [24:0] min_top,
        input logic [3:0]  level
    );
        logic [28:0] prod;
        logic [28:0] diff;
        prod = 29'(level) * 29'(step);
        diff = 29'(base) - prod;
        if ((prod > 29'(base)) || (diff < 29'(min_top)))
            gravity_top = min_top;
        else
            gravity_top = base - prod[24:0];
    endfunction

endpackage

// File: rtl/interval_counter.sv
// -----------------------------------------------------------------------------
// interval_counter
// 25-bit up-counter with synchronous clear and hold (freeze when enable=0).
// tc flags count >= top, so a top that shrinks below the running count
// still terminates on the very next cycle instead of wrapping.
// Ports:
//   clk, reset      : clock, async active-high reset
//   clear           : synchronous clear (wins over enable)
//   enable          : advance by one this cycle
//   top             : terminal value of the current interval
//   count           : current count
//   tc              : terminal-count flag (combinational)
// -----------------------------------------------------------------------------
module interval_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [24:0] top,
    output logic [24:0] count,
    output logic        tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 25'd1;
    end

    assign tc = (count >= top);

endmodule

// File: rtl/drop_scheduler.sv
// -----------------------------------------------------------------------------
// drop_scheduler
// Generates gravity (fall_tick) and lock-delay (lock_tick) pulses for the
// active piece. Gravity speeds up with level and soft drop; a landed piece
// runs a lock-delay interval that restarts if the piece is freed.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | not playing; counter held at 0, waits for start
//   FALL  | gravity interval running; fall_tick at terminal count
//   LOCK  | piece landed; lock_tick at terminal count, then FALL
//   PAUSE | counter frozen; pause_toggle returns to the saved state
//
// Ports:
//   clk, reset           : clock, async active-high reset
//   start                : one-cycle pulse, IDLE -> FALL
//   game_over            : level, forces IDLE (highest priority)
//   pause_toggle         : one-cycle pulse, enter/leave PAUSE
//   level[3:0]           : game level 0..15
//   soft_drop            : level, down key held
//   landed               : level, piece cannot move down
//   fall_tick, lock_tick : registered one-cycle request pulses
//   state[1:0]           : current FSM state
// -----------------------------------------------------------------------------
module drop_scheduler
    import tetris_pkg::*;
#(
    parameter logic [24:0] BASE_TOP = DEF_BASE_TOP,
    parameter logic [24:0] STEP     = DEF_STEP,
    parameter logic [24:0] MIN_TOP  = DEF_MIN_TOP,
    parameter logic [24:0] SOFT_TOP = DEF_SOFT_TOP,
    parameter logic [24:0] LOCK_TOP = DEF_LOCK_TOP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       game_over,
    input  logic       pause_toggle,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       landed,
    output logic       fall_tick,
    output logic       lock_tick,
    output logic [1:0] state
);

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    logic        fall_d, lock_d;
    logic        cnt_clear, cnt_enable;
    logic        cnt_tc;
    logic [24:0] cnt_value;
    logic [24:0] grav_top, fall_top, cur_top;

    assign grav_top = gravity_top(BASE_TOP, STEP, MIN_TOP, level);
    assign fall_top = (soft_drop && (SOFT_TOP < grav_top)) ? SOFT_TOP : grav_top;
    assign cur_top  = (state_q == ST_LOCK) ? LOCK_TOP : fall_top;

    interval_counter u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .top    (cur_top),
        .count  (cnt_value),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            saved_q   <= ST_FALL;
            fall_tick <= 1'b0;
            lock_tick <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            fall_tick <= fall_d;
            lock_tick <= lock_d;
        end
    end

    // Counter is cleared on every real state entry; entering and leaving
    // PAUSE leaves it untouched so the interval resumes where it stopped.
    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        fall_d     = 1'b0;
        lock_d     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        if (game_over) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_clear = 1'b1;
                    if (start)
                        state_d = ST_FALL;
                end
                ST_FALL: begin
                    if (pause_toggle) begin
                        state_d = ST_PAUSE;
                        saved_d = ST_FALL;
                    end else if (landed) begin
                        state_d   = ST_LOCK;
                        cnt_clear = 1'b1;
                    end else if (cnt_tc) begin
                        fall_d    = 1'b1;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (pause_toggle) begin
                        state_d = ST_PAUSE;
                        saved_d = ST_LOCK;
                    end else if (!landed) begin
                        state_d   = ST_FALL;
                        cnt_clear = 1'b1;
                    end else if (cnt_tc) begin
                        lock_d    = 1'b1;
                        state_d   = ST_FALL;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause_toggle)
                        state_d = saved_q;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_drop_scheduler.sv
module tb_drop_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       game_over = 1'b0;
    logic       pause_toggle = 1'b0;
    logic [3:0] level = 4'd0;
    logic       soft_drop = 1'b0;
    logic       landed = 1'b0;
    logic       fall_tick;
    logic       lock_tick;
    logic [1:0] state;

    int passed = 0;
    int total  = 0;
    int n;
    int illegal_ticks = 0;
    int pause_ticks;
    int idle_ticks;

    localparam int LIMIT = 200;

    drop_scheduler #(
        .BASE_TOP (25'd20),
        .STEP     (25'd2),
        .MIN_TOP  (25'd4),
        .SOFT_TOP (25'd3),
        .LOCK_TOP (25'd10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .game_over    (game_over),
        .pause_toggle (pause_toggle),
        .level        (level),
        .soft_drop    (soft_drop),
        .landed       (landed),
        .fall_tick    (fall_tick),
        .lock_tick    (lock_tick),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Ticks must never overlap and never appear in IDLE or PAUSE.
    always @(negedge clk) begin
        if ((fall_tick && lock_tick) ||
            ((fall_tick || lock_tick) && (state == 2'd0 || state == 2'd3)))
            illegal_ticks++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the chosen tick is seen (0 = not seen within LIMIT).
    task automatic measure(input bit want_lock, output int cnt);
        cnt = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (want_lock ? lock_tick : fall_tick) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Run k cycles counting any tick seen.
    task automatic quiet(input int k, output int seen);
        seen = 0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            if (fall_tick || lock_tick) seen++;
        end
    endtask

    initial begin
        // reset state
        #2;
        check("rst_state", state, 0);
        check("rst_fall", fall_tick, 0);
        check("rst_lock", lock_tick, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        quiet(10, idle_ticks);
        check("idle_no_tick", idle_ticks, 0);
        check("idle_state", state, 0);

        // level 0 gravity: first tick 21 edges after start, then every 21
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("start_state", state, 1);
        measure(0, n);
        check("l0_first", n, 21);
        measure(0, n);
        check("l0_period", n, 21);
        cycles(1);
        check("tick_width", fall_tick, 0);
        measure(0, n);
        check("l0_period2", n, 20);

        // level 15 saturates at MIN_TOP
        level = 4'd15;
        measure(0, n);
        check("l15_period", n, 5);
        measure(0, n);
        check("l15_period2", n, 5);

        // soft drop at level 0 -> top 3
        level = 4'd0;
        soft_drop = 1'b1;
        measure(0, n);
        check("soft_period", n, 4);
        measure(0, n);
        check("soft_period2", n, 4);
        soft_drop = 1'b0;
        measure(0, n);
        check("after_soft", n, 21);

        // lock delay
        landed = 1'b1;
        cycles(1);
        check("lock_entry", state, 2);
        check("lock_entry_nofall", fall_tick, 0);
        measure(1, n);
        check("lock_tick_delay", n, 11);
        check("lock_returns_fall", state, 1);
        check("lock_nofall", fall_tick, 0);
        cycles(1);
        check("relock", state, 2);
        cycles(6);
        landed = 1'b0;
        cycles(1);
        check("unland_state", state, 1);
        check("unland_nolock", lock_tick, 0);
        measure(0, n);
        check("unland_fall", n, 21);

        // pause at counter 7, 50 cycles, resume -> tick 14 later
        cycles(7);
        pause_toggle = 1'b1;
        cycles(1);
        pause_toggle = 1'b0;
        check("pause_state", state, 3);
        quiet(50, pause_ticks);
        check("pause_no_tick", pause_ticks, 0);
        check("pause_held", state, 3);
        pause_toggle = 1'b1;
        cycles(1);
        pause_toggle = 1'b0;
        check("resume_state", state, 1);
        measure(0, n);
        check("resume_fall", n, 14);

        // game_over at terminal count
        cycles(20);
        game_over = 1'b1;
        cycles(1);
        check("go_state", state, 0);
        check("go_nofall", fall_tick, 0);
        game_over = 1'b0;
        quiet(10, idle_ticks);
        check("go_quiet", idle_ticks, 0);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        measure(0, n);
        check("go_restart", n, 21);

        // async reset while lock_tick is high
        landed = 1'b1;
        cycles(1);
        measure(1, n);
        check("pre_rst_lock", n, 11);
        reset = 1'b1;
        #1;
        check("async_rst_lock", lock_tick, 0);
        check("async_rst_state", state, 0);
        #1;
        reset = 1'b0;
        landed = 1'b0;
        quiet(60, idle_ticks);
        check("post_rst_quiet", idle_ticks, 0);
        check("post_rst_state", state, 0);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        measure(0, n);
        check("post_rst_start", n, 21);

        check("illegal_ticks", illegal_ticks, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/drop_scheduler.md
DROP_SCHEDULER -- requirements
Module: drop_scheduler

Interface
REQ-001 Parameter BASE_TOP, default 25'd12_000_000, is the gravity interval top at level 0.
REQ-002 Parameter STEP, default 25'd1_000_000, is the amount the top shrinks per level.
REQ-003 Parameter MIN_TOP, default 25'd1_000_000, is the floor for the gravity top.
REQ-004 Parameter SOFT_TOP, default 25'd600_000, is the top while soft drop is held.
REQ-005 Parameter LOCK_TOP, default 25'd6_000_000, is the lock-delay top.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: a one-cycle pulse that begins play.
REQ-009 Port game_over, input, 1 bit: a level signal that stops play.
REQ-010 Port pause_toggle, input, 1 bit: a one-cycle pulse that enters or leaves pause.
REQ-011 Port level, input, 4 bits: the current game level, 0..15.
REQ-012 Port soft_drop, input, 1 bit: a level signal, high while the down key is held.
REQ-013 Port landed, input, 1 bit: a level signal, high while the active piece cannot move down.
REQ-014 Port fall_tick, output, 1 bit: a one-cycle pulse requesting a move down by one row.
REQ-015 Port lock_tick, output, 1 bit: a one-cycle pulse requesting a piece lock.
REQ-016 Port state, output, 2 bits: the current FSM state encoding.

Function
REQ-017 The FSM SHALL have the states IDLE=0, FALL=1, LOCK=2 and PAUSE=3.
REQ-018 Gravity top SHALL be BASE_TOP - level*STEP, computed at 29 bits and saturated to MIN_TOP when the result is below MIN_TOP or negative.
REQ-019 Effective FALL top SHALL be min(SOFT_TOP, gravity top) while soft_drop=1, and gravity top otherwise.
REQ-020 The 25-bit interval counter SHALL clear on every state entry and increment by 1 each cycle in FALL or LOCK.
- The counter reaches terminal count when counter >= top; this handles a top that drops mid-count.
- At terminal count the counter clears, which gives a period of top+1 cycles.
REQ-021 In FALL, at terminal count with landed=0, the block SHALL pulse fall_tick, registered, for exactly 1 cycle.
REQ-022 In FALL, landed=1 SHALL cause a transition to LOCK on the next edge with no fall_tick.
REQ-023 In LOCK, landed=0 SHALL cause a return to FALL with the counter cleared (lock-delay reset).
REQ-024 In LOCK, at terminal count against LOCK_TOP, the block SHALL pulse lock_tick for 1 cycle and then return to FALL.
REQ-025 IDLE->FALL SHALL occur only on start; start is ignored in every other state.
REQ-026 pause_toggle in FALL or LOCK SHALL enter PAUSE, save the return state and freeze the counter.
REQ-027 pause_toggle in PAUSE SHALL restore the saved state with the counter value unchanged.
REQ-028 game_over=1 SHALL force IDLE from any state and suppress any tick in that cycle.
REQ-029 Priority within a cycle SHALL be game_over > pause_toggle > landed transition > terminal count.
REQ-030 fall_tick and lock_tick SHALL never both be high in the same cycle and SHALL never be high in IDLE or PAUSE.

Reset
REQ-031 reset=1 SHALL asynchronously force state=IDLE, counter=0, saved state=FALL, fall_tick=0 and lock_tick=0.
REQ-032 Reset asserted mid-interval SHALL discard all progress; no tick is emitted after release until a new start.

Structure
REQ-033 Shared package tetris_pkg SHALL hold the state enum and the default values of all five tops.
REQ-034 Sub-module interval_counter SHALL implement the loadable, freezable 25-bit counter with its >= terminal compare; the FSM SHALL reside in drop_scheduler.

Verification (parameters BASE_TOP=20, STEP=2, MIN_TOP=4, SOFT_TOP=3, LOCK_TOP=10)
REQ-035 Level 0, start pulse, landed=0 -> fall_tick every 21 cycles, with the first tick 21 cycles after start.
REQ-036 Level 15 -> fall_tick period 5 (saturated at MIN_TOP); then soft_drop=1 at level 0 -> period 4.
REQ-037 landed=1 held -> no fall_tick; lock_tick 11 cycles after LOCK entry; landed dropping at cycle 6 -> FALL, no lock_tick.
REQ-038 pause_toggle at counter=7 in FALL, held 50 cycles, then pause_toggle -> no ticks in PAUSE, next fall_tick 14 cycles after resume.
REQ-039 game_over coinciding with terminal count -> no tick, state=0; a later start restarts with a full 21-cycle period.
REQ-040 reset pulsed mid-LOCK -> outputs 0 immediately (asynchronous); no ticks after release until start.
